// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
// Requester ids and the hard-wired $zero register index.
package regfile_wb_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CNT_W_DEF  = 16;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  localparam int ZERO_REG = 0;

  function automatic logic [1:0] one_hot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant with a last-grant register.
// Grant is combinational; last_grant moves on every grant.
module rr_arbiter_2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       contend,
  output logic       last_grant
);

  always_comb begin
    grant   = 2'b00;
    contend = enable & valid[0] & valid[1];
    if (!enable) begin
      grant = 2'b00;
    end else if (contend) begin
      // The requester that did not win last time goes first.
      grant = one_hot(~last_grant);
    end else if (valid[0]) begin
      grant = one_hot(REQ_ALU);
    end else if (valid[1]) begin
      grant = one_hot(REQ_MEM);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= REQ_MEM;
    end else if (grant != 2'b00) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load writeback.
// Registered write outputs, $zero filter, saturating contention counter.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              wr_stall,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_src,
  output logic [CNT_W-1:0]  conflict_count
);

  logic [1:0]        grant;
  logic              contend;
  logic              last_grant;
  logic              enable;
  logic              xfer;
  logic              sel;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  assign enable = ~wr_stall & ~reset;

  rr_arbiter_2 u_arb (
    .clock      (clock),
    .reset      (reset),
    .valid      ({req1_valid, req0_valid}),
    .enable     (enable),
    .grant      (grant),
    .contend    (contend),
    .last_grant (last_grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign xfer = |grant;
  assign sel  = grant[1];

  always_comb begin
    sel_addr = req0_addr;
    sel_data = req0_data;
    if (sel == REQ_MEM) begin
      sel_addr = req1_addr;
      sel_data = req1_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_src  <= REQ_ALU;
    end else if (xfer) begin
      // $zero writes are consumed but never reach the register file.
      wr_en   <= (sel_addr != ADDR_W'(ZERO_REG));
      wr_addr <= sel_addr;
      wr_data <= sel_data;
      wr_src  <= sel;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      conflict_count <= '0;
    end else if (contend && (conflict_count != '1)) begin
      conflict_count <= conflict_count + 1'b1;
    end
  end

endmodule
